ctrl_pipe: RTL and testbench

Pipelined control unit for the custom CPU. It decodes the opcode of the instruction in ID into a 13-bit control bundle and carries that bundle through EX, MEM and WB registers. It also handles external stall, branch flush and a load-use interlock, and keeps a saturating retired-instruction counter. It sits between fetch/ID and the datapath stage registers, and replaces purely combinational decode in the pipelined core.

---
 rtl/ctrl_pipe.sv | 157 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decodes the ID opcode into a 13-bit control bundle and carries it through
// EX/MEM/WB, with global stall, branch flush, load-use interlock and a saturating retire counter.
module ctrl_pipe #(
    parameter int INSTR_W        = 6,
    parameter int CNT_W          = 16,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               stall,
    input  logic               branch_taken,
    output logic [12:0]        ex_ctrl,
    output logic [12:0]        mem_ctrl,
    output logic [12:0]        wb_ctrl,
    output logic               ex_valid,
    output logic               mem_valid,
    output logic               wb_valid,
    output logic               load_use_stall,
    output logic [CNT_W-1:0]   retire_cnt
);

    localparam logic [2:0] OP_LSW  = 3'd0;
    localparam logic [2:0] OP_SET  = 3'd1;
    localparam logic [2:0] OP_BNE  = 3'd2;
    localparam logic [2:0] OP_PAR  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_LSOR = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    localparam int B_REGWR  = 12;
    localparam int B_MEMWR  = 11;
    localparam int B_BRREL  = 10;
    localparam int B_REGMEM = 9;
    localparam int B_ALUSRC = 8;
    localparam int B_DATSRC = 7;
    localparam int B_RDADDR = 6;
    localparam int B_LDST   = 5;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    function automatic logic [12:0] decode(input logic [2:0] op, input logic [2:0] sub);
        logic [12:0] c;
        c = 13'h0000;
        case (op)
            OP_LSW: begin
                if (sub == 3'd0) begin
                    c[B_MEMWR] = 1'b1;
                end else begin
                    c[B_REGWR] = 1'b1;
                    c[B_LDST]  = 1'b1;
                end
            end
            OP_SET: begin
                c[B_REGWR]  = 1'b1;
                c[B_REGMEM] = 1'b1;
                c[4:3]      = 2'd2;
            end
            OP_BNE: begin
                c[B_BRREL]  = 1'b1;
                c[B_RDADDR] = 1'b1;
                c[2:0]      = 3'd2;
            end
            OP_PAR, OP_XOR, OP_LSOR: begin
                c[B_REGWR]  = 1'b1;
                c[B_DATSRC] = 1'b1;
                c[4:3]      = 2'd1;
                c[2:0]      = op;
            end
            OP_ADD: begin
                c[B_REGWR]  = 1'b1;
                c[B_ALUSRC] = 1'b1;
                c[B_DATSRC] = 1'b1;
                c[B_RDADDR] = 1'b1;
                c[4:3]      = 2'd1;
                c[2:0]      = 3'd4;
            end
            default: c = 13'h0000;
        endcase
        return c;
    endfunction

    logic [2:0]       op_s;
    logic [2:0]       sub_s;
    logic             reads_reg_s;
    logic             lus_s;
    logic [12:0]      ex_ctrl_nxt_s;
    logic             ex_valid_nxt_s;
    logic [12:0]      ex_ctrl_r;
    logic [12:0]      mem_ctrl_r;
    logic [12:0]      wb_ctrl_r;
    logic             ex_valid_r;
    logic             mem_valid_r;
    logic             wb_valid_r;
    logic [CNT_W-1:0] retire_cnt_r;

    assign op_s        = instr[INSTR_W-1 -: 3];
    assign sub_s       = instr[INSTR_W-4 -: 3];
    assign reads_reg_s = instr_valid && (op_s != OP_SET) && (op_s != OP_NOP);
    // A taken branch kills the ID instruction, so it never needs to wait for the lw.
    assign lus_s = LOAD_USE_STALL && ex_valid_r && ex_ctrl_r[B_REGWR] && ex_ctrl_r[B_LDST]
                   && reads_reg_s && !branch_taken;

    // EX-stage input: decoded bundle or a bubble
    always_comb begin
        ex_ctrl_nxt_s  = 13'h0000;
        ex_valid_nxt_s = 1'b0;
        if (instr_valid && !branch_taken && !lus_s) begin
            ex_ctrl_nxt_s  = decode(op_s, sub_s);
            ex_valid_nxt_s = 1'b1;
        end else begin
            ex_ctrl_nxt_s  = 13'h0000;
            ex_valid_nxt_s = 1'b0;
        end
    end

    // Stage registers; a stall freezes the whole pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_r   <= 13'h0000;
            mem_ctrl_r  <= 13'h0000;
            wb_ctrl_r   <= 13'h0000;
            ex_valid_r  <= 1'b0;
            mem_valid_r <= 1'b0;
            wb_valid_r  <= 1'b0;
        end else if (!stall) begin
            ex_ctrl_r   <= ex_ctrl_nxt_s;
            ex_valid_r  <= ex_valid_nxt_s;
            mem_ctrl_r  <= ex_ctrl_r;
            mem_valid_r <= ex_valid_r;
            wb_ctrl_r   <= mem_ctrl_r;
            wb_valid_r  <= mem_valid_r;
        end
    end

    // Saturating count of instructions leaving WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= {CNT_W{1'b0}};
        end else if (!stall && wb_valid_r && (retire_cnt_r != CNT_MAX)) begin
            retire_cnt_r <= retire_cnt_r + CNT_ONE;
        end
    end

    assign ex_ctrl        = ex_ctrl_r;
    assign mem_ctrl       = mem_ctrl_r;
    assign wb_ctrl        = wb_ctrl_r;
    assign ex_valid       = ex_valid_r;
    assign mem_valid      = mem_valid_r;
    assign wb_valid       = wb_valid_r;
    assign load_use_stall = lus_s;
    assign retire_cnt     = retire_cnt_r;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: decode table, interlock/branch/stall sequences,
// WB-retirement scoreboard, async reset and counter saturation (CNT_W=2 instance).
module tb_ctrl_pipe;

    logic        clk;
    logic        rst_n;
    logic [5:0]  instr;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;

    logic [12:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic        ex_valid, mem_valid, wb_valid, load_use_stall;
    logic [15:0] retire_cnt;

    logic [12:0] ex_ctrl_n, mem_ctrl_n, wb_ctrl_n;
    logic        ex_valid_n, mem_valid_n, wb_valid_n, load_use_stall_n;
    logic [15:0] retire_cnt_n;

    logic [12:0] ex_ctrl_s, mem_ctrl_s, wb_ctrl_s;
    logic        ex_valid_s, mem_valid_s, wb_valid_s, load_use_stall_s;
    logic [1:0]  retire_cnt_s;

    ctrl_pipe #(.INSTR_W(6), .CNT_W(16), .LOAD_USE_STALL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .branch_taken(branch_taken),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .load_use_stall(load_use_stall), .retire_cnt(retire_cnt)
    );

    ctrl_pipe #(.INSTR_W(6), .CNT_W(16), .LOAD_USE_STALL(1'b0)) dut_nolu (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .branch_taken(branch_taken),
        .ex_ctrl(ex_ctrl_n), .mem_ctrl(mem_ctrl_n), .wb_ctrl(wb_ctrl_n),
        .ex_valid(ex_valid_n), .mem_valid(mem_valid_n), .wb_valid(wb_valid_n),
        .load_use_stall(load_use_stall_n), .retire_cnt(retire_cnt_n)
    );

    ctrl_pipe #(.INSTR_W(6), .CNT_W(2), .LOAD_USE_STALL(1'b1)) dut_small (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .branch_taken(branch_taken),
        .ex_ctrl(ex_ctrl_s), .mem_ctrl(mem_ctrl_s), .wb_ctrl(wb_ctrl_s),
        .ex_valid(ex_valid_s), .mem_valid(mem_valid_s), .wb_valid(wb_valid_s),
        .load_use_stall(load_use_stall_s), .retire_cnt(retire_cnt_s)
    );

    typedef struct {
        logic [5:0]  instr;
        logic        valid;
        logic [12:0] ex;
        logic        exv;
    } vec_t;

    int          n_chk;
    int          n_fail;
    logic [12:0] sb_q[$];
    logic [15:0] m_cnt;
    logic        m_ex_lw;
    logic        mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] exp_dec(input logic [5:0] i);
        case (i[5:3])
            3'd0:    return (i[2:0] == 3'd0) ? 13'h0800 : 13'h1020;
            3'd1:    return 13'h1210;
            3'd2:    return 13'h0442;
            3'd3:    return 13'h108B;
            3'd4:    return 13'h11CC;
            3'd5:    return 13'h108D;
            3'd6:    return 13'h108E;
            default: return 13'h0000;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input logic [5:0] i, input logic v, input logic st, input logic br);
        logic exp_lus;
        logic acc;
        instr = i; instr_valid = v; stall = st; branch_taken = br;
        #1;
        exp_lus = m_ex_lw && v && (i[5:3] != 3'd1) && (i[5:3] != 3'd7) && !br;
        check("load_use_stall", load_use_stall, exp_lus);
        check("load_use_stall_disabled", load_use_stall_n, 1'b0);
        acc = !st && v && !br && !exp_lus;
        if (acc) sb_q.push_back(exp_dec(i));
        @(posedge clk);
        if (!st) m_ex_lw = acc && (i[5:3] == 3'd0) && (i[2:0] != 3'd0);
        #1;
    endtask

    task automatic reset_dut();
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ex_ctrl", ex_ctrl, 13'h0000);
        check("rst_mem_ctrl", mem_ctrl, 13'h0000);
        check("rst_wb_ctrl", wb_ctrl, 13'h0000);
        check("rst_valids", {ex_valid, mem_valid, wb_valid}, 3'b000);
        check("rst_load_use_stall", load_use_stall, 1'b0);
        check("rst_retire_cnt", retire_cnt, 16'h0000);
        check("rst_retire_cnt_small", retire_cnt_s, 2'd0);
        instr = 6'h00; instr_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        sb_q.delete();
        m_cnt = 16'h0000;
        m_ex_lw = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
    endtask

    // Scoreboard: every instruction leaving WB must match the oldest accepted one
    always @(negedge clk) begin
        if (mon_en) begin
            check("retire_cnt", retire_cnt, m_cnt);
            if (wb_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected_retire: got wb_ctrl %0h, expected none", wb_ctrl);
                end else begin
                    check("wb_ctrl", wb_ctrl, sb_q.pop_front());
                end
                m_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        logic [12:0] s_ex, s_mem, s_wb;
        logic [15:0] s_cnt;
        tbl = '{
            '{6'h01, 1'b1, 13'h1020, 1'b1},
            '{6'h00, 1'b1, 13'h0000, 1'b0},
            '{6'h00, 1'b1, 13'h0800, 1'b1},
            '{6'h08, 1'b1, 13'h1210, 1'b1},
            '{6'h10, 1'b1, 13'h0442, 1'b1},
            '{6'h18, 1'b1, 13'h108B, 1'b1},
            '{6'h20, 1'b1, 13'h11CC, 1'b1},
            '{6'h28, 1'b1, 13'h108D, 1'b1},
            '{6'h30, 1'b1, 13'h108E, 1'b1},
            '{6'h07, 1'b1, 13'h1020, 1'b1},
            '{6'h38, 1'b1, 13'h0000, 1'b1},
            '{6'h0F, 1'b1, 13'h1210, 1'b1},
            '{6'h20, 1'b0, 13'h0000, 1'b0},
            '{6'h05, 1'b1, 13'h1020, 1'b1},
            '{6'h0C, 1'b1, 13'h1210, 1'b1}
        };
        n_chk = 0; n_fail = 0;
        m_cnt = 16'h0000; m_ex_lw = 1'b0; mon_en = 1'b0;
        rst_n = 1'b0; instr = 6'h00; instr_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        reset_dut();

        // single ADD through the pipe
        cyc(6'h20, 1'b1, 1'b0, 1'b0);
        check("lat_ex_ctrl", ex_ctrl, 13'h11CC);
        cyc(6'h00, 1'b0, 1'b0, 1'b0);
        check("lat_mem_ctrl", mem_ctrl, 13'h11CC);
        cyc(6'h00, 1'b0, 1'b0, 1'b0);
        check("lat_wb_ctrl", wb_ctrl, 13'h11CC);
        cyc(6'h00, 1'b0, 1'b0, 1'b0);
        check("lat_retire_cnt", retire_cnt, 16'd1);

        for (int k = 0; k < 15; k++) begin
            cyc(tbl[k].instr, tbl[k].valid, 1'b0, 1'b0);
            check("tbl_ex_ctrl", ex_ctrl, tbl[k].ex);
            check("tbl_ex_valid", ex_valid, tbl[k].exv);
        end

        // lw then ADD: one bubble, ADD re-presented
        cyc(6'h01, 1'b1, 1'b0, 1'b0);
        cyc(6'h20, 1'b1, 1'b0, 1'b0);
        check("lu_bubble_ctrl", ex_ctrl, 13'h0000);
        check("lu_bubble_valid", ex_valid, 1'b0);
        check("lu_disabled_ex_ctrl", ex_ctrl_n, 13'h11CC);
        cyc(6'h20, 1'b1, 1'b0, 1'b0);
        check("lu_after_ex_ctrl", ex_ctrl, 13'h11CC);

        // branch flush, also overriding a pending load-use
        cyc(6'h20, 1'b1, 1'b0, 1'b1);
        check("br_ex_ctrl", ex_ctrl, 13'h0000);
        check("br_ex_valid", ex_valid, 1'b0);
        cyc(6'h01, 1'b1, 1'b0, 1'b0);
        cyc(6'h20, 1'b1, 1'b0, 1'b1);
        check("br_lu_ex_valid", ex_valid, 1'b0);
        cyc(6'h20, 1'b1, 1'b0, 1'b0);
        check("br_lu_after_ex_ctrl", ex_ctrl, 13'h11CC);

        // full pipe frozen for three cycles
        cyc(6'h28, 1'b1, 1'b0, 1'b0);
        cyc(6'h18, 1'b1, 1'b0, 1'b0);
        s_ex = ex_ctrl; s_mem = mem_ctrl; s_wb = wb_ctrl; s_cnt = retire_cnt;
        for (int k = 0; k < 3; k++) begin
            cyc(6'h08, 1'b1, 1'b1, 1'b0);
            check("stall_ex_ctrl", ex_ctrl, s_ex);
            check("stall_mem_ctrl", mem_ctrl, s_mem);
            check("stall_wb_ctrl", wb_ctrl, s_wb);
            check("stall_retire_cnt", retire_cnt, s_cnt);
        end
        cyc(6'h08, 1'b1, 1'b0, 1'b0);
        check("resume_ex_ctrl", ex_ctrl, 13'h1210);
        check("resume_mem_ctrl", mem_ctrl, 13'h108B);

        // async reset mid-stream
        cyc(6'h20, 1'b1, 1'b0, 1'b0);
        reset_dut();

        // counter saturation on the CNT_W=2 instance
        for (int k = 0; k < 5; k++) cyc(6'h38, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(6'h00, 1'b0, 1'b0, 1'b0);
        check("sat_retire_cnt_small", retire_cnt_s, 2'd3);
        check("sat_retire_cnt_wide", retire_cnt, 16'd5);

        for (int k = 0; k < 4; k++) cyc(6'h00, 1'b0, 1'b0, 1'b0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
